// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths and FSM state encoding.
package instr_fetch_unit_pkg;

    localparam int unsigned IF_PC_W    = 8;
    localparam int unsigned IF_INSTR_W = 32;
    localparam int unsigned IF_DEPTH   = 2;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Fetch FIFO: circular buffer of {pc, instr} entries with occupancy count and flush.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned W     = IF_PC_W + IF_INSTR_W,
    parameter int unsigned DEPTH = IF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [W-1:0]                  wdata,
    output logic                          empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic [W-1:0]                  head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads over req/ack, buffers results, applies redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W    = IF_PC_W,
    parameter int unsigned INSTR_W = IF_INSTR_W,
    parameter int unsigned DEPTH   = IF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               redir_valid,
    input  logic [PC_W-1:0]    redir_base,
    input  logic [PC_W-1:0]    redir_offset
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned ENT_W = PC_W + INSTR_W;

    if_state_e         state;
    if_state_e         state_nxt;
    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   fetch_pc_nxt;
    logic [PC_W-1:0]   drop_addr;
    logic [PC_W-1:0]   drop_addr_nxt;
    logic [PC_W-1:0]   target;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  occ;
    logic              empty;
    logic              pop;
    logic              push;
    logic              space;
    logic              room_after_push;
    logic [ENT_W-1:0]  head;

    assign target = redir_base + redir_offset;
    assign pop    = out_valid & out_ready;

    // Occupancy once this cycle's pop is taken; count >= pop since pop implies non-empty.
    assign occ             = count - CNT_W'(pop);
    assign space           = occ < CNT_W'(DEPTH);
    assign room_after_push = occ < CNT_W'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IF_IDLE;
            fetch_pc  <= '0;
            drop_addr <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            drop_addr <= drop_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        drop_addr_nxt = drop_addr;
        push          = 1'b0;
        case (state)
            IF_IDLE: begin
                if (redir_valid)  fetch_pc_nxt = target;
                else if (space)   state_nxt    = IF_REQ;
            end
            IF_REQ: begin
                if (redir_valid) begin
                    fetch_pc_nxt = target;
                    if (imem_ack) begin
                        state_nxt = IF_IDLE;
                    end else begin
                        state_nxt     = IF_DROP;
                        drop_addr_nxt = fetch_pc;
                    end
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + PC_W'(1);
                    state_nxt    = room_after_push ? IF_REQ : IF_IDLE;
                end
            end
            IF_DROP: begin
                // A redirect coinciding with the drop ack still retargets, but the
                // squashed transaction is complete so the FSM leaves DROP.
                if (redir_valid) fetch_pc_nxt = target;
                if (imem_ack)    state_nxt    = IF_IDLE;
            end
            default: state_nxt = IF_IDLE;
        endcase
    end

    fetch_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir_valid),
        .wdata ({fetch_pc, imem_rdata}),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    assign imem_req  = (state != IF_IDLE);
    assign imem_addr = (state == IF_DROP) ? drop_addr : fetch_pc;
    assign out_valid = !empty;
    assign out_pc    = empty ? '0 : head[ENT_W-1:INSTR_W];
    assign out_instr = empty ? '0 : head[INSTR_W-1:0];

endmodule
